// File: rtl/mat_stream_pkg.sv
// mat_stream_pkg
// Shared types and helpers for the matrix result streamer.
//   state_e   : streamer FSM states (IDLE, STREAM)
//   idx_width : width of an index port for n entries, never less than 1 bit
package mat_stream_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mat_macros.vh
// mat_macros.vh
// Shared float / packed-matrix helper macros used by the matrix datapath.
// Expects EXP_WIDTH and MAN_WIDTH (and BIAS for the *_BIAS_PARAMS form)
// to be visible in the scope where the macros are expanded.
//   FLOAT_WIDTH             : sign + exponent + mantissa bits
//   MAT_WIDTH(r, c)         : bits in a packed r x c matrix
//   MAT_SELECT(i, k, c)     : indexed part-select of element (i,k), row-major
//   FLOAT_PRPG_PARAMS       : propagate float format parameters to a child
//   FLOAT_PRPG_BIAS_PARAMS  : same, including the exponent bias
`ifndef MAT_MACROS_VH
`define MAT_MACROS_VH

`define FLOAT_WIDTH (1 + EXP_WIDTH + MAN_WIDTH)
`define MAT_WIDTH(r, c) ((r) * (c) * `FLOAT_WIDTH)
`define MAT_SELECT(i, k, c) ((((i) * (c)) + (k)) * `FLOAT_WIDTH) +: `FLOAT_WIDTH
`define FLOAT_PRPG_PARAMS .EXP_WIDTH(EXP_WIDTH), .MAN_WIDTH(MAN_WIDTH)
`define FLOAT_PRPG_BIAS_PARAMS .EXP_WIDTH(EXP_WIDTH), .MAN_WIDTH(MAN_WIDTH), .BIAS(BIAS)

`endif

// File: rtl/mat_result_streamer_float_is_nan.sv
// float_is_nan
// Combinational NaN classifier for a packed float: all-ones exponent and a
// nonzero mantissa. Infinities (zero mantissa) are not NaN.
//   value  in  FLOAT_WIDTH : float bits
//   is_nan out 1           : value is a (quiet or signalling) NaN
`include "mat_macros.vh"

module float_is_nan #(
    parameter int EXP_WIDTH = 8,
    parameter int MAN_WIDTH = 23
) (
    input  logic [`FLOAT_WIDTH-1:0] value,
    output logic                    is_nan
);

    logic [EXP_WIDTH-1:0] exp_bits;
    logic [MAN_WIDTH-1:0] man_bits;

    assign exp_bits = value[MAN_WIDTH +: EXP_WIDTH];
    assign man_bits = value[MAN_WIDTH-1:0];
    assign is_nan   = (&exp_bits) && (|man_bits);

endmodule

// File: rtl/mat_result_streamer.sv
// mat_result_streamer
// Captures one packed I x K float matrix in a single beat and replays it as a
// row-major stream of elements with row/column tags and a last flag.
// Optional feature macro: MAT_STREAM_NAN_FLAG_EN adds the out_nan output.
//   clk, rst        : clock, asynchronous active-high reset
//   in_valid/ready  : matrix input handshake (in_ready is combinational)
//   in_mat          : packed matrix, element (i,k) at MAT_SELECT(i,k,K)
//   out_valid/ready : element output handshake
//   out_data        : element bits, unmodified
//   out_row/out_col : element indices
//   out_last        : element (I-1,K-1)
//   out_nan         : (optional) current valid element is a NaN
`include "mat_macros.vh"

module mat_result_streamer
    import mat_stream_pkg::*;
#(
    parameter int EXP_WIDTH = 8,
    parameter int MAN_WIDTH = 23,
    parameter int BIAS      = -127,
    parameter int I         = 4,
    parameter int K         = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [`MAT_WIDTH(I, K)-1:0]         in_mat,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [`FLOAT_WIDTH-1:0]             out_data,
    output logic [idx_width(I)-1:0]             out_row,
    output logic [idx_width(K)-1:0]             out_col,
    output logic                                out_last
`ifdef MAT_STREAM_NAN_FLAG_EN
    ,
    output logic                                out_nan
`endif
);

    localparam int FW  = `FLOAT_WIDTH;
    localparam int MW  = `MAT_WIDTH(I, K);
    localparam int N   = I * K;
    localparam int RW  = idx_width(I);
    localparam int CW  = idx_width(K);
    localparam int FLW = idx_width(N);
    localparam logic [RW-1:0] ROW_LAST = RW'(I - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(K - 1);

    state_e          state_q, state_d;
    logic [MW-1:0]   mat_q, mat_d;
    logic [RW-1:0]   row_q, row_d;
    logic [CW-1:0]   col_q, col_d;
    logic            out_valid_q, out_valid_d;
    logic            out_last_q, out_last_d;
    logic [FW-1:0]   out_data_q, out_data_d;
    logic [FLW-1:0]  flat_d;
    logic [FW-1:0]   elem_d [N];
    logic            out_fire;
    logic            in_fire;

    assign out_fire = out_valid_q && out_ready;
    // Accepting while the last element leaves lets matrices run back-to-back.
    assign in_ready = (state_q == IDLE) || (out_fire && out_last_q);
    assign in_fire  = in_valid && in_ready;

    // Unpack the next-cycle matrix so the element mux indexes a flat array.
    for (genvar gi = 0; gi < I; gi++) begin : g_row
        for (genvar gk = 0; gk < K; gk++) begin : g_col
            assign elem_d[gi*K + gk] = mat_d[`MAT_SELECT(gi, gk, K)];
        end
    end

    always_comb begin
        state_d     = state_q;
        mat_d       = mat_q;
        row_d       = row_q;
        col_d       = col_q;
        out_valid_d = out_valid_q;
        if (in_fire) begin
            mat_d       = in_mat;
            row_d       = '0;
            col_d       = '0;
            state_d     = STREAM;
            out_valid_d = 1'b1;
        end else if (out_fire) begin
            if (out_last_q) begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                row_d       = '0;
                col_d       = '0;
            end else if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
        // row*K + col is always below N, so truncating K is harmless when row is 0.
        flat_d     = FLW'(row_d) * FLW'(K) + FLW'(col_d);
        out_data_d = elem_d[flat_d];
        out_last_d = out_valid_d && (row_d == ROW_LAST) && (col_d == COL_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mat_q       <= '0;
            row_q       <= '0;
            col_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            mat_q       <= mat_d;
            row_q       <= row_d;
            col_q       <= col_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_row   = row_q;
    assign out_col   = col_q;
    assign out_last  = out_last_q;

`ifdef MAT_STREAM_NAN_FLAG_EN
    logic is_nan_d;
    logic out_nan_q;

    float_is_nan #(
        `FLOAT_PRPG_PARAMS
    ) u_float_is_nan (
        .value  (out_data_d),
        .is_nan (is_nan_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_nan_q <= 1'b0;
        end else begin
            out_nan_q <= out_valid_d && is_nan_d;
        end
    end

    assign out_nan = out_nan_q;
`endif

endmodule

// File: tb/tb_mat_result_streamer.sv
// tb_mat_result_streamer
// Directed bench for mat_result_streamer (4x4, single precision).
module tb_mat_result_streamer;

    localparam int FW = 32;
    localparam int N  = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [N*FW-1:0] in_mat;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_data;
    logic [1:0]      out_row;
    logic [1:0]      out_col;
    logic            out_last;
`ifdef MAT_STREAM_NAN_FLAG_EN
    logic            out_nan;
`endif

    int checks   = 0;
    int failures = 0;

    mat_result_streamer #(
        .EXP_WIDTH (8),
        .MAN_WIDTH (23),
        .BIAS      (-127),
        .I         (4),
        .K         (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mat    (in_mat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_last  (out_last)
`ifdef MAT_STREAM_NAN_FLAG_EN
        ,
        .out_nan   (out_nan)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          beat;
        logic [1:0]  row;
        logic [1:0]  col;
        logic [31:0] data;
        logic        last;
    } beat_vec_t;

    beat_vec_t   spot [6];
    logic [31:0] mat_a [N];
    logic [31:0] mat_b [N];
    logic [31:0] mat_c [N];
    logic [31:0] mat_d [N];

    function automatic logic [N*FW-1:0] pack(input logic [31:0] m [N]);
        logic [N*FW-1:0] p;
        for (int i = 0; i < N; i++) p[i*FW +: FW] = m[i];
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end else begin
            $display("ok   %s value=%h", name, act);
        end
    endtask

    // {valid,row,col,last,data} of the element the model expects at beat b.
    task automatic check_beat(input string tag, input int b, input logic [31:0] exp_data);
        check($sformatf("%s_beat%0d", tag, b),
              {26'd0, out_valid, out_row, out_col, out_last, out_data},
              {26'd0, 1'b1, 2'(b / 4), 2'(b % 4), (b == 15), exp_data});
    endtask

    task automatic load(input logic [31:0] m [N]);
        in_mat   = pack(m);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        for (int b = 0; b < N; b++) begin
            mat_a[b] = 32'h3F800000 + 32'(b);
            mat_b[b] = 32'hC0000000 + 32'(b) * 32'h00011111;
            mat_c[b] = 32'h41200000 + 32'(b) * 32'h3;
            mat_d[b] = mat_a[b];
        end
        // bit-exact specials
        mat_b[0] = 32'h7F800000;
        mat_b[1] = 32'hFF800000;
        mat_b[2] = 32'h7FC00001;
        mat_b[3] = 32'h00000001;
        mat_b[4] = 32'h80000000;
        mat_b[15] = 32'hFFFFFFFF;
        mat_d[11] = 32'h7FC00000;
        mat_d[12] = 32'h7F800000;

        spot[0] = '{0,  2'd0, 2'd0, 32'h3F800000, 1'b0};
        spot[1] = '{5,  2'd1, 2'd1, 32'h3F800005, 1'b0};
        spot[2] = '{6,  2'd1, 2'd2, 32'h3F800006, 1'b0};
        spot[3] = '{11, 2'd2, 2'd3, 32'h3F80000B, 1'b0};
        spot[4] = '{12, 2'd3, 2'd0, 32'h3F80000C, 1'b0};
        spot[5] = '{15, 2'd3, 2'd3, 32'h3F80000F, 1'b1};

        // reset and idle
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_mat = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_fields", {out_row, out_col, out_last, out_data}, 0);
`ifdef MAT_STREAM_NAN_FLAG_EN
        check("rst_out_nan", out_nan, 0);
`endif

        // full-rate stream
        out_ready = 1'b1;
        load(mat_a);
        for (int b = 0; b < N; b++) begin
            @(negedge clk);
            check_beat("full", b, mat_a[b]);
            check($sformatf("full_in_ready%0d", b), in_ready, (b == 15));
            for (int j = 0; j < 6; j++) begin
                if (spot[j].beat == b) begin
                    check($sformatf("spot_beat%0d", b),
                          {out_row, out_col, out_last, out_data},
                          {spot[j].row, spot[j].col, spot[j].last, spot[j].data});
                end
            end
            tick();
        end
        @(negedge clk);
        check("full_done_valid", out_valid, 0);
        check("full_done_in_ready", in_ready, 1);

        // stalls: out_ready 1,0,0,1,0,0,... ; in_mat scribbled during stream
        begin
            int idx = 0;
            int c = 0;
            load(mat_b);
            while (idx < N && c < 200) begin
                out_ready = (c % 3 == 0);
                in_mat = {16{$urandom}};
                @(negedge clk);
                check_beat("stall", idx, mat_b[idx]);
                check($sformatf("stall_in_ready_c%0d", c), in_ready, (out_ready && idx == 15));
                if (out_ready) idx++;
                c++;
                tick();
            end
            check("stall_all_beats", idx, N);
            @(negedge clk);
            check("stall_done_valid", out_valid, 0);
        end

        // back-to-back matrices with in_valid held high
        out_ready = 1'b1;
        in_mat = pack(mat_a);
        in_valid = 1'b1;
        tick();
        in_mat = pack(mat_c);
        for (int b = 0; b < 2 * N; b++) begin
            @(negedge clk);
            if (b < N) check_beat("b2b_m0", b, mat_a[b]);
            else       check_beat("b2b_m1", b - N, mat_c[b - N]);
            tick();
            if (b == 15) in_valid = 1'b0;
        end
        @(negedge clk);
        check("b2b_done_valid", out_valid, 0);

        // asynchronous reset during beat 7
        load(mat_a);
        repeat (7) tick();
        @(negedge clk);
        check_beat("pre_rst", 7, mat_a[7]);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_idx", {out_row, out_col, out_last}, 0);
        @(negedge clk);
        rst = 1'b0;
        load(mat_c);
        for (int b = 0; b < N; b++) begin
            @(negedge clk);
            check_beat("post_rst", b, mat_c[b]);
            tick();
        end

`ifdef MAT_STREAM_NAN_FLAG_EN
        load(mat_d);
        for (int b = 0; b < N; b++) begin
            @(negedge clk);
            check_beat("nan", b, mat_d[b]);
            check($sformatf("nan_flag%0d", b), out_nan, (b == 11));
            tick();
        end
        @(negedge clk);
        check("nan_idle_flag", out_nan, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
